// File: rtl/coproc_pkg.sv
// Shared co-processor definitions: opcode encoding, command field positions
// and the issue FSM state type.
package coproc_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_MUL = 3'b100,
        OP_SLT = 3'b101,
        OP_SGT = 3'b110,
        OP_XOR = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP
    } state_e;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 29;
    localparam int SRC1_MSB = 28;
    localparam int SRC1_LSB = 15;
    localparam int SRC2_MSB = 14;
    localparam int SRC2_LSB = 1;

endpackage

// File: rtl/coproc_issue_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit found when
// searching upward from last_grant+1, wrapping modulo NREQ.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves
        // a value unassigned and no latch is inferred.
        valid = 1'b0;
        idx   = '0;
        // Walk from the farthest candidate back to last_grant+1; the last hit wins.
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(last_grant) + k) % NREQ]) begin
                valid = 1'b1;
                idx   = IW'((int'(last_grant) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/coproc_issue_arbiter.sv
// Round-robin issue arbiter feeding a single co-processor FIFO write port,
// with MUL back-off gap and last-slot (afull) protection.
module coproc_issue_arbiter
    import coproc_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int DW      = 32,
    parameter  int MUL_GAP = 1,
    localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               p_clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] cmd_in,
    input  logic               full,
    input  logic               afull,
    output logic [NREQ-1:0]    ack,
    output logic               w_req,
    output logic [DW-1:0]      data_out,
    output logic [IW-1:0]      grant_id,
    output logic [15:0]        issued_cnt
);

    localparam int            GW       = (MUL_GAP > 1) ? $clog2(MUL_GAP) : 1;
    localparam bit            GAP_EN   = (MUL_GAP > 0);
    localparam logic [GW-1:0] GAP_INIT = GW'((MUL_GAP > 0) ? MUL_GAP - 1 : 0);

    state_e          state, state_nxt;
    logic [IW-1:0]   last_grant;
    logic            afull_hold;
    logic [GW-1:0]   gap_cnt;
    logic [NREQ-1:0] eligible;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_onehot;
    logic [DW-1:0]   pick_cmd;
    logic            last_mul;
    logic            gap_done;
    logic            state_ok;
    logic            issue;

    // A requester acked this cycle is still showing req; skip it until it re-evaluates.
    assign eligible = req & ~ack;
    assign last_mul = (data_out[OPC_MSB:OPC_LSB] == OP_MUL);
    assign gap_done = (gap_cnt == '0);

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req        (eligible),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    always_comb begin
        pick_onehot = '0;
        pick_cmd    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == pick_idx) begin
                pick_onehot[i] = 1'b1;
                pick_cmd       = cmd_in[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_ok = 1'b0;
        case (state)
            ST_IDLE:  state_ok = 1'b1;
            ST_ISSUE: state_ok = !last_mul;
            ST_GAP:   state_ok = gap_done;
            default:  state_ok = 1'b0;
        endcase

        // The hold only bites while afull is still high; sampling afull=0 releases it.
        issue = state_ok && pick_valid && !full && !(afull_hold && afull);

        if (issue)
            state_nxt = ST_ISSUE;
        else if (state == ST_ISSUE && last_mul && GAP_EN)
            state_nxt = ST_GAP;
        else if (state == ST_GAP && !gap_done)
            state_nxt = ST_GAP;
        else
            state_nxt = ST_IDLE;
    end

    always_ff @(posedge p_clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            w_req      <= 1'b0;
            ack        <= '0;
            data_out   <= '0;
            grant_id   <= '0;
            issued_cnt <= '0;
            afull_hold <= 1'b0;
            last_grant <= IW'(NREQ - 1);
            gap_cnt    <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state      <= state_nxt;
            w_req      <= issue;
            ack        <= issue ? pick_onehot : '0;
            afull_hold <= issue ? afull : (afull_hold & afull);
            if (issue) begin
                data_out   <= pick_cmd;
                grant_id   <= pick_idx;
                last_grant <= pick_idx;
                issued_cnt <= issued_cnt + 16'd1;
            end
            if (state_nxt == ST_GAP)
                gap_cnt <= (state == ST_GAP) ? gap_cnt - 1'b1 : GAP_INIT;
        end
    end

endmodule

// File: tb/tb_coproc_issue_arbiter.sv
// Self-checking bench for coproc_issue_arbiter: per-cycle vector table with a
// scoreboard queue, plus hand-written reset and counter-wrap sequences.
module tb_coproc_issue_arbiter;

    logic         p_clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] cmd_in;
    logic         full;
    logic         afull;
    logic [3:0]   ack;
    logic         w_req;
    logic [31:0]  data_out;
    logic [1:0]   grant_id;
    logic [15:0]  issued_cnt;

    int n_checks = 0;
    int n_errors = 0;

    coproc_issue_arbiter #(.NREQ(4), .DW(32), .MUL_GAP(1)) dut (
        .p_clk      (p_clk),
        .rst        (rst),
        .req        (req),
        .cmd_in     (cmd_in),
        .full       (full),
        .afull      (afull),
        .ack        (ack),
        .w_req      (w_req),
        .data_out   (data_out),
        .grant_id   (grant_id),
        .issued_cnt (issued_cnt)
    );

    always #5 p_clk = ~p_clk;

    typedef struct {
        logic [3:0] req;
        logic       full;
        logic       afull;
        logic [3:0] mul_mask;
        logic       exp_w;
        logic [3:0] exp_ack;
        logic [1:0] exp_gid;
    } vec_t;

    typedef struct {
        logic        w;
        logic [3:0]  ack;
        logic [1:0]  gid;
        logic [31:0] data;
        logic [15:0] cnt;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    vec_t        v;
    exp_t        e;
    logic [15:0] exp_cnt;
    int          gaps;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_cmd(input int i, input logic mul);
        logic [31:0] c;
        if (mul)
            c = 32'h9000_4002;
        else
            c = {3'b000, 14'(i + 1), 14'(3 * i + 5), 1'b0};
        return c;
    endfunction

    function automatic vec_t mk(input logic [3:0] r, input logic f, input logic af,
                                input logic [3:0] mm, input logic ew,
                                input logic [3:0] ea, input logic [1:0] eg);
        vec_t t;
        t.req = r; t.full = f; t.afull = af; t.mul_mask = mm;
        t.exp_w = ew; t.exp_ack = ea; t.exp_gid = eg;
        return t;
    endfunction

    task automatic drive(input vec_t d);
        req   = d.req;
        full  = d.full;
        afull = d.afull;
        for (int i = 0; i < 4; i++)
            cmd_in[i*32 +: 32] = mk_cmd(i, d.mul_mask[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req = '0; full = 1'b0; afull = 1'b0; cmd_in = '0;
        exp_cnt = '0;
        repeat (2) @(posedge p_clk);
        #1;
        check("reset w_req",      32'(w_req),      32'd0);
        check("reset ack",        32'(ack),        32'd0);
        check("reset data_out",   data_out,        32'd0);
        check("reset grant_id",   32'(grant_id),   32'd0);
        check("reset issued_cnt", 32'(issued_cnt), 32'd0);
        @(negedge p_clk) rst = 1'b1;

        // All four held, no MUL: 0,1,2,3,0 back to back.
        vecs.push_back(mk(4'b1111, 0, 0, 4'b0000, 1, 4'b0001, 2'd0));
        vecs.push_back(mk(4'b1111, 0, 0, 4'b0000, 1, 4'b0010, 2'd1));
        vecs.push_back(mk(4'b1111, 0, 0, 4'b0000, 1, 4'b0100, 2'd2));
        vecs.push_back(mk(4'b1111, 0, 0, 4'b0000, 1, 4'b1000, 2'd3));
        vecs.push_back(mk(4'b1111, 0, 0, 4'b0000, 1, 4'b0001, 2'd0));
        vecs.push_back(mk(4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 2'd0));
        // MUL from 2, then one gap cycle, then ADD from 3.
        vecs.push_back(mk(4'b1100, 0, 0, 4'b0100, 1, 4'b0100, 2'd2));
        vecs.push_back(mk(4'b1000, 0, 0, 4'b0100, 0, 4'b0000, 2'd0));
        vecs.push_back(mk(4'b1000, 0, 0, 4'b0100, 1, 4'b1000, 2'd3));
        vecs.push_back(mk(4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 2'd0));
        // afull: one write into the last slot, then hold until afull drops.
        vecs.push_back(mk(4'b0011, 0, 1, 4'b0000, 1, 4'b0001, 2'd0));
        vecs.push_back(mk(4'b0010, 0, 1, 4'b0000, 0, 4'b0000, 2'd0));
        vecs.push_back(mk(4'b0010, 0, 1, 4'b0000, 0, 4'b0000, 2'd0));
        vecs.push_back(mk(4'b0010, 0, 0, 4'b0000, 1, 4'b0010, 2'd1));
        vecs.push_back(mk(4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 2'd0));
        // full blocks for five cycles, issue follows one cycle after it drops.
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(4'b0001, 1, 0, 4'b0000, 0, 4'b0000, 2'd0));
        vecs.push_back(mk(4'b0001, 0, 0, 4'b0000, 1, 4'b0001, 2'd0));
        vecs.push_back(mk(4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 2'd0));

        for (int n = 0; n < vecs.size(); n++) begin
            v = vecs[n];
            drive(v);
            if (v.exp_w) exp_cnt = exp_cnt + 16'd1;
            e.w    = v.exp_w;
            e.ack  = v.exp_ack;
            e.gid  = v.exp_gid;
            e.data = mk_cmd(int'(v.exp_gid), v.mul_mask[v.exp_gid]);
            e.cnt  = exp_cnt;
            sb.push_back(e);
            @(posedge p_clk);
            #1;
            e = sb.pop_front();
            check($sformatf("v%0d w_req", n),      32'(w_req),      32'(e.w));
            check($sformatf("v%0d ack", n),        32'(ack),        32'(e.ack));
            check($sformatf("v%0d issued_cnt", n), 32'(issued_cnt), 32'(e.cnt));
            if (e.w) begin
                check($sformatf("v%0d grant_id", n), 32'(grant_id), 32'(e.gid));
                check($sformatf("v%0d data_out", n), data_out,      e.data);
            end
        end
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        // Reset in the middle of an ISSUE cycle.
        drive(mk(4'b1111, 0, 0, 4'b0000, 0, 4'b0000, 2'd0));
        @(posedge p_clk);
        #1;
        check("pre-reset w_req", 32'(w_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid reset w_req",      32'(w_req),      32'd0);
        check("mid reset ack",        32'(ack),        32'd0);
        check("mid reset data_out",   data_out,        32'd0);
        check("mid reset grant_id",   32'(grant_id),   32'd0);
        check("mid reset issued_cnt", 32'(issued_cnt), 32'd0);
        req = 4'b1000;
        @(negedge p_clk) rst = 1'b1;
        @(posedge p_clk);
        #1;
        check("post reset w_req",    32'(w_req),    32'd1);
        check("post reset grant_id", 32'(grant_id), 32'd3);
        check("post reset ack",      32'(ack),      32'b1000);
        req = 4'b0000;

        // issued_cnt wrap: 65535 continuous issues, then one more.
        @(negedge p_clk) rst = 1'b0;
        @(negedge p_clk) rst = 1'b1;
        req  = 4'b1111;
        gaps = 0;
        for (int i = 0; i < 65535; i++) begin
            @(posedge p_clk);
            #1;
            if (w_req !== 1'b1) gaps++;
        end
        check("wrap run w_req gaps", 32'(gaps),       32'd0);
        check("pre-wrap issued_cnt", 32'(issued_cnt), 32'h0000_FFFF);
        @(posedge p_clk);
        #1;
        check("wrapped issued_cnt",  32'(issued_cnt), 32'd0);
        req = 4'b0000;
        @(posedge p_clk);
        #1;
        check("final idle w_req", 32'(w_req), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/coproc_issue_arbiter.md
COPROC_ISSUE_ARBITER -- requirements
Module: coproc_issue_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing the co-processor write port.
REQ-002 SHALL have parameter DW, default 32: instruction width; opcode is [31:29], src1 is [28:15], src2 is [14:1].
REQ-003 SHALL have parameter MUL_GAP, default 1: number of idle cycles forced after issuing a MUL (opcode 3'b100).
REQ-004 SHALL have port p_clk, input, 1 bit: the only clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req, input, NREQ bits: req[i] high means requester i holds a valid command.
REQ-007 SHALL have port cmd_in, input, NREQ*DW bits: the command of requester i is cmd_in[i*DW +: DW], stable while req[i] is high.
REQ-008 SHALL have port full, input, 1 bit: the co-processor FIFO is full.
REQ-009 SHALL have port afull, input, 1 bit: the co-processor FIFO has at most one free slot.
REQ-010 SHALL have port ack, output, NREQ bits: a one-cycle pulse on ack[i] means the command of requester i has been issued.
REQ-011 SHALL have port w_req, output, 1 bit: the registered write strobe to the co-processor.
REQ-012 SHALL have port data_out, output, DW bits: the registered issued command, valid while w_req is high.
REQ-013 SHALL have port grant_id, output, clog2(NREQ) bits: the requester index of the current issue.
REQ-014 SHALL have port issued_cnt, output, 16 bits: the total number of commands issued.

Function
REQ-015 SHALL implement a three-state FSM:
- IDLE: no issue this cycle.
- ISSUE: w_req high for exactly the cycles spent in this state.
- GAP: forced idle.
REQ-016 SHALL treat requester i as eligible when req[i]=1 and ack[i] is not high in the current cycle.
REQ-017 SHALL decide to issue at a rising edge when all of the following hold:
- some requester is eligible;
- full=0;
- no afull hold is active;
- the state is IDLE, or the state is ISSUE and the command just issued is not a MUL.
REQ-018 SHALL apply the same edge to every output on an issue: w_req=1, data_out=selected command, grant_id=selected index, ack[sel]=1, issued_cnt+1, and state ISSUE; latency from req to w_req/ack is 1 cycle.
REQ-019 SHALL select requesters round-robin: search starts at last_grant+1 modulo NREQ, and last_grant updates on every issue.
REQ-020 SHALL move from ISSUE to GAP when the command just issued has opcode 3'b100 and MUL_GAP>0; the block stays in GAP for exactly MUL_GAP cycles with w_req=0, then enters IDLE or ISSUE per REQ-017.
REQ-021 SHALL move from ISSUE to IDLE when no issue condition holds.
REQ-022 SHALL set an afull hold when it issues while afull=1; the hold blocks further issue until afull is sampled 0, so at most one write lands in the last free slot.
REQ-023 SHALL never issue while full=1; it waits with req held and without dropping or reordering commands.
REQ-024 SHALL wrap issued_cnt from 16'hFFFF to 16'h0000 without any flag.
REQ-025 SHALL keep ack one-hot or zero, and SHALL never let w_req=1 without exactly one ack bit high.
REQ-026 SHALL not decode or alter command content apart from the opcode check for MUL.

Reset
REQ-027 SHALL on rst=0, immediately and asynchronously, force:
- state = IDLE;
- w_req = 0, ack = 0, data_out = 0, grant_id = 0, issued_cnt = 0;
- afull hold cleared;
- last_grant = NREQ-1, so requester 0 wins first.
REQ-028 SHALL abort an in-flight issue or GAP on reset mid-operation; no ack is produced for that cycle, and requesters re-present their commands after reset.

Structure
REQ-029 SHALL take from shared package coproc_pkg the opcode constants (ADD=000, SUB=001, AND=010, OR=011, MUL=100, SLT=101, SGT=110, XOR=111), the FSM state typedef, and the field positions.
REQ-030 SHALL instantiate one combinational sub-module rr_pick, which takes (req vector, last_grant) and returns a valid flag and an index.

Verification
REQ-031 SHALL cover: reset, then req=4'b1111 held with full=0 and no MUL -> grants 0,1,2,3,0 on consecutive cycles, with w_req continuously high.
REQ-032 SHALL cover: req[2]=1 with cmd 32'h9000_4002 (MUL) and req[3]=1 with an ADD -> issue 2, then one GAP cycle with w_req=0, then issue 3.
REQ-033 SHALL cover: full=1 with req=4'b0001 for 5 cycles -> w_req=0 and ack=0 throughout; full drops -> issue 1 cycle later with grant_id=0.
REQ-034 SHALL cover: afull=1 with req=4'b0011 -> exactly one issue (requester 0), then w_req=0 until afull=0, then requester 1 is issued.
REQ-035 SHALL cover: issued_cnt preloaded by 65535 issues, one more issue -> issued_cnt=0.
REQ-036 SHALL cover: rst asserted during an ISSUE cycle -> all outputs 0 within the same cycle; after release with req=4'b1000, the first grant_id is 3.
